// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART timing defaults, FSM state encoding and parity helper
package uart_pkg;

   localparam int DEF_CLKS_PER_BIT = 16;
   localparam int DEF_DATA_BITS    = 8;
   localparam int MAX_DATA_BITS    = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_state_e;

   // Parity over a zero-extended data word; odd=1 inverts even parity.
   function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period counter with sync clear and end-of-bit pulse
module uart_baud_cnt
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic bit_end
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // High on the last clock of a bit period, so the owner advances on the wrap edge.
   assign bit_end = en && !clr && (cnt_q == CNT_LAST);

   // Count 0..CLKS_PER_BIT-1 while enabled, wrap to zero, clear takes priority.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter with one-deep holding register for gapless frames
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int DATA_BITS    = DEF_DATA_BITS,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 txd,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int BIT_W = $clog2(DATA_BITS);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
   localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

   uart_state_e          state_q, state_d;
   logic [DATA_BITS-1:0] hold_q, hold_d;
   logic                 hold_full_q, hold_full_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
   logic                 stop_idx_q, stop_idx_d;
   logic                 txd_q, txd_d;
   logic                 tx_done_q, tx_done_d;

   logic accept;
   logic bit_end;
   logic parity_bit;

   assign accept     = tx_valid && !hold_full_q;
   assign parity_bit = calc_parity(MAX_DATA_BITS'(data_q), PARITY_ODD != 0);

   assign tx_ready = !hold_full_q;
   assign txd      = txd_q;
   assign tx_busy  = (state_q != ST_IDLE);
   assign tx_done  = tx_done_q;

   uart_baud_cnt #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk     (clk),
      .rst     (rst),
      .clr     (state_q == ST_IDLE),
      .en      (state_q != ST_IDLE),
      .bit_end (bit_end)
   );

   // Next-state logic; txd is computed for the state being entered so the line stays registered.
   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      shift_d     = shift_q;
      data_d      = data_q;
      bit_idx_d   = bit_idx_q;
      stop_idx_d  = stop_idx_q;
      txd_d       = txd_q;
      tx_done_d   = 1'b0;

      // Accept and drain are mutually exclusive because tx_ready is low while full.
      if (accept) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (hold_full_q) begin
               state_d     = ST_START;
               shift_d     = hold_q;
               data_d      = hold_q;
               hold_full_d = 1'b0;
               txd_d       = 1'b0;
            end
         end
         ST_START: begin
            if (bit_end) begin
               state_d   = ST_DATA;
               bit_idx_d = '0;
               txd_d     = shift_q[0];
               shift_d   = shift_q >> 1;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               if (bit_idx_q == BIT_LAST) begin
                  stop_idx_d = 1'b0;
                  if (PARITY_EN != 0) begin
                     state_d = ST_PARITY;
                     txd_d   = parity_bit;
                  end else begin
                     state_d = ST_STOP;
                     txd_d   = 1'b1;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + BIT_W'(1);
                  txd_d     = shift_q[0];
                  shift_d   = shift_q >> 1;
               end
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               state_d    = ST_STOP;
               stop_idx_d = 1'b0;
               txd_d      = 1'b1;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               if (stop_idx_q == STOP_LAST) begin
                  tx_done_d = 1'b1;
                  if (hold_full_q) begin
                     state_d     = ST_START;
                     shift_d     = hold_q;
                     data_d      = hold_q;
                     hold_full_d = 1'b0;
                     txd_d       = 1'b0;
                  end else begin
                     state_d = ST_IDLE;
                     txd_d   = 1'b1;
                  end
               end else begin
                  stop_idx_d = stop_idx_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            txd_d   = 1'b1;
         end
      endcase
   end

   // State and datapath registers; reset aborts any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shift_q     <= '0;
         data_q      <= '0;
         bit_idx_q   <= '0;
         stop_idx_q  <= 1'b0;
         txd_q       <= 1'b1;
         tx_done_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         bit_idx_q   <= bit_idx_d;
         stop_idx_q  <= stop_idx_d;
         txd_q       <= txd_d;
         tx_done_q   <= tx_done_d;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx in four frame formats
`timescale 1ns/1ps
module tb_uart_tx;

   logic       clk;
   logic       rst;
   logic [7:0] tx_data [4];
   logic [3:0] tx_valid;
   logic [3:0] tx_ready;
   logic [3:0] txd;
   logic [3:0] tx_busy;
   logic [3:0] tx_done;

   int checks = 0;
   int errors = 0;

   // 0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2
   uart_tx #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
      .clk(clk), .rst(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
      .tx_ready(tx_ready[0]), .txd(txd[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]));
   uart_tx #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
      .clk(clk), .rst(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
      .tx_ready(tx_ready[1]), .txd(txd[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]));
   uart_tx #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
      .clk(clk), .rst(rst), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
      .tx_ready(tx_ready[2]), .txd(txd[2]), .tx_busy(tx_busy[2]), .tx_done(tx_done[2]));
   uart_tx #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
      .clk(clk), .rst(rst), .tx_data(tx_data[3]), .tx_valid(tx_valid[3]),
      .tx_ready(tx_ready[3]), .txd(txd[3]), .tx_busy(tx_busy[3]), .tx_done(tx_done[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Offer byte b; optionally scramble tx_data while stalled. Returns stalled cycle count.
   task automatic push(input int k, input logic [7:0] b, input bit wiggle, output int wait_cyc);
      int n;
      tx_valid[k] = 1'b1;
      tx_data[k]  = b;
      n = 0;
      while (tx_ready[k] !== 1'b1 && n < 400) begin
         if (wiggle) tx_data[k] = 8'($urandom);
         @(negedge clk);
         n++;
      end
      check($sformatf("push%0d_%02h_ready_seen", k, b), 32'(n < 400), 1);
      tx_data[k] = b;
      @(negedge clk);
      tx_valid[k] = 1'b0;
      tx_data[k]  = 8'($urandom);
      wait_cyc = n;
   endtask

   // Wait for the start bit, then check every cycle of every bit; ends on the cycle tx_done should be high.
   task automatic expect_frame(input int k, input logic [7:0] b, input int npar, input logic pbit,
                               input int nstop, output int gap);
      int   n;
      int   bad;
      int   done_bad;
      int   nbits;
      logic exp_lvl;
      n = 0;
      while (txd[k] !== 1'b0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      gap = n;
      check($sformatf("frame%0d_%02h_start_seen", k, b), 32'(n < 400), 1);
      if (n < 400) begin
         nbits    = 1 + 8 + npar + nstop;
         done_bad = 0;
         for (int i = 0; i < nbits; i++) begin
            if (i == 0)                     exp_lvl = 1'b0;
            else if (i <= 8)                exp_lvl = b[i-1];
            else if (npar != 0 && i == 9)   exp_lvl = pbit;
            else                            exp_lvl = 1'b1;
            bad = 0;
            for (int c = 0; c < 16; c++) begin
               if (txd[k] !== exp_lvl) bad++;
               if (tx_busy[k] !== 1'b1) bad++;
               if ((i != 0 || c != 0) && tx_done[k] !== 1'b0) done_bad++;
               @(negedge clk);
            end
            check($sformatf("frame%0d_%02h_bit%0d_bad_cycles", k, b, i), bad, 0);
         end
         check($sformatf("frame%0d_%02h_done_early", k, b), done_bad, 0);
         check($sformatf("frame%0d_%02h_done_pulse", k, b), tx_done[k], 1);
      end
   endtask

   initial begin
      int w_a, w_b, w_c;
      int g_a, g_b, g_c;
      int bad;

      rst      = 1'b1;
      tx_valid = '0;
      for (int k = 0; k < 4; k++) tx_data[k] = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state of all formats
      for (int k = 0; k < 4; k++) begin
         check($sformatf("rst%0d_txd", k), txd[k], 1);
         check($sformatf("rst%0d_busy", k), tx_busy[k], 0);
         check($sformatf("rst%0d_done", k), tx_done[k], 0);
         check($sformatf("rst%0d_ready", k), tx_ready[k], 1);
      end

      // Single 8N1 frame of 0x55
      push(0, 8'h55, 1'b0, w_a);
      check("single_accept_wait", w_a, 0);
      check("single_ready_after_accept", tx_ready[0], 0);
      check("single_txd_before_start", txd[0], 1);
      expect_frame(0, 8'h55, 0, 1'b0, 1, g_a);
      check("single_start_latency", g_a, 1);
      @(negedge clk);
      check("single_done_one_cycle", tx_done[0], 0);
      check("single_busy_end", tx_busy[0], 0);
      bad = 0;
      repeat (20) begin
         if (txd[0] !== 1'b1 || tx_busy[0] !== 1'b0) bad++;
         @(negedge clk);
      end
      check("single_idle_high", bad, 0);

      // Back-to-back 0xA5 then 0x3C with tx_valid held
      push(0, 8'hA5, 1'b0, w_a);
      fork
         begin
            push(0, 8'h3C, 1'b0, w_b);
            check("b2b_second_stall", w_b, 1);
            check("b2b_ready_while_full", tx_ready[0], 0);
         end
         begin
            expect_frame(0, 8'hA5, 0, 1'b0, 1, g_a);
            check("b2b_first_latency", g_a, 1);
            expect_frame(0, 8'h3C, 0, 1'b0, 1, g_b);
            check("b2b_no_gap", g_b, 0);
         end
      join
      @(negedge clk);
      check("b2b_busy_end", tx_busy[0], 0);

      // Even parity, 0x07 -> parity 1, 176-cycle frame
      push(1, 8'h07, 1'b0, w_a);
      expect_frame(1, 8'h07, 1, 1'b1, 1, g_a);
      check("even_par_latency", g_a, 1);
      @(negedge clk);
      check("even_par_busy_end", tx_busy[1], 0);

      // Odd parity, 0x00 -> parity 1
      push(2, 8'h00, 1'b0, w_a);
      expect_frame(2, 8'h00, 1, 1'b1, 1, g_a);
      check("odd_par_latency", g_a, 1);
      @(negedge clk);

      // Two stop bits, two queued bytes: 32 high cycles then immediate start
      push(3, 8'hC3, 1'b0, w_a);
      fork
         push(3, 8'h5A, 1'b0, w_b);
         begin
            expect_frame(3, 8'hC3, 0, 1'b0, 2, g_a);
            expect_frame(3, 8'h5A, 0, 1'b0, 2, g_b);
            check("stop2_no_gap", g_b, 0);
         end
      join
      @(negedge clk);
      check("stop2_busy_end", tx_busy[3], 0);

      // Reset 50 cycles into a frame
      push(0, 8'h81, 1'b0, w_a);
      repeat (50) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_txd", txd[0], 1);
      check("midrst_busy", tx_busy[0], 0);
      check("midrst_ready", tx_ready[0], 1);
      bad = 0;
      repeat (200) begin
         if (txd[0] !== 1'b1 || tx_done[0] !== 1'b0) bad++;
         @(negedge clk);
      end
      check("midrst_quiet", bad, 0);
      push(0, 8'hE7, 1'b0, w_a);
      expect_frame(0, 8'hE7, 0, 1'b0, 1, g_a);
      check("midrst_next_latency", g_a, 1);
      @(negedge clk);

      // Backpressure with tx_data scrambled while stalled
      push(0, 8'h96, 1'b0, w_a);
      fork
         begin
            push(0, 8'h0F, 1'b0, w_b);
            push(0, 8'h69, 1'b1, w_c);
            check("bp_stall_cycles", w_c, 159);
         end
         begin
            expect_frame(0, 8'h96, 0, 1'b0, 1, g_a);
            expect_frame(0, 8'h0F, 0, 1'b0, 1, g_b);
            check("bp_gap_0f", g_b, 0);
            expect_frame(0, 8'h69, 0, 1'b0, 1, g_c);
            check("bp_gap_69", g_c, 0);
         end
      join
      @(negedge clk);
      check("bp_busy_end", tx_busy[0], 0);
      check("bp_txd_end", txd[0], 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
